// File: rtl/state_reg_bank_if.sv
// state_reg_bank_if: write/stack/read bus of the state register bank.
// Names carry the bank's view: i_* flow into the bank, o_* flow out of it.
interface state_reg_bank_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int CH_BITS  = 2
);
   logic [CHANNELS-1:0]       i_ch_reset;
   logic                      i_wr_en;
   logic [CH_BITS-1:0]        i_wr_ch;
   logic [1:0]                i_wr_mode;
   logic [WIDTH-1:0]          i_wr_data;
   logic                      i_push;
   logic                      i_pop;
   logic [CH_BITS-1:0]        i_stk_ch;
   logic [CH_BITS-1:0]        i_rd_ch;
   logic [CHANNELS-1:0]       i_chg_clr;
   logic [WIDTH-1:0]          o_rd_data;
   logic [CHANNELS*WIDTH-1:0] o_state_flat;
   logic [CHANNELS-1:0]       o_stk_empty;
   logic [CHANNELS-1:0]       o_stk_full;
   logic [CHANNELS-1:0]       o_stk_err;
   logic [CHANNELS-1:0]       o_change_flag;
   modport master (
      output i_ch_reset, i_wr_en, i_wr_ch, i_wr_mode, i_wr_data, i_push, i_pop, i_stk_ch, i_rd_ch, i_chg_clr,
      input  o_rd_data, o_state_flat, o_stk_empty, o_stk_full, o_stk_err, o_change_flag
   );
   modport slave (
      input  i_ch_reset, i_wr_en, i_wr_ch, i_wr_mode, i_wr_data, i_push, i_pop, i_stk_ch, i_rd_ch, i_chg_clr,
      output o_rd_data, o_state_flat, o_stk_empty, o_stk_full, o_stk_err, o_change_flag
   );
endinterface

// File: rtl/state_reg_bank.sv
// state_reg_bank: per-channel state words with bit-level write modes and LIFO context stacks.
// Optional STATE_REG_CHANGE_DET_EN adds sticky per-channel word-changed flags.
module state_reg_bank #(
   parameter int                WIDTH     = 8,
   parameter int                CHANNELS  = 4,
   parameter int                CH_BITS   = 2,
   parameter int                DEPTH     = 4,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input logic               CLK,
   input logic               reset,
   state_reg_bank_if.slave   bus
);
   localparam int PW = $clog2(DEPTH + 1);
   localparam int SW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int NS = 2 ** CH_BITS;
   logic [WIDTH-1:0]    w_words [NS];
   logic [CHANNELS-1:0] w_empty_v, w_full_v, w_err_v;
`ifdef STATE_REG_CHANGE_DET_EN
   logic [CHANNELS-1:0] w_chg_v;
`endif
   genvar g;
   generate
      for (g = 0; g < NS; g++) begin : g_slot
         if (g < CHANNELS) begin : g_ch
            logic [WIDTH-1:0] r_word;
            logic [WIDTH-1:0] r_stack [DEPTH];
            logic [PW-1:0]    r_ptr;
            logic             r_err;
            logic             w_rst, w_wr, w_push, w_pop, w_full, w_empty;
            logic [WIDTH-1:0] w_wval, w_next;
            logic [PW-1:0]    w_ptr_next;
            always_comb begin
               w_rst      = reset || bus.i_ch_reset[g];
               w_wr       = bus.i_wr_en && bus.i_wr_ch == CH_BITS'(g);
               w_push     = bus.i_push && !bus.i_pop && bus.i_stk_ch == CH_BITS'(g);
               w_pop      = bus.i_pop && !bus.i_push && bus.i_stk_ch == CH_BITS'(g);
               w_full     = r_ptr == PW'(DEPTH);
               w_empty    = r_ptr == '0;
               w_wval     = bus.i_wr_mode == 2'b00 ? bus.i_wr_data :
                            bus.i_wr_mode == 2'b01 ? r_word | bus.i_wr_data :
                            bus.i_wr_mode == 2'b10 ? r_word & ~bus.i_wr_data :
                                                     r_word ^ bus.i_wr_data;
               // a successful pop outranks a same-cycle write
               w_next     = (w_pop && !w_empty) ? r_stack[SW'(r_ptr - 1'b1)] : w_wr ? w_wval : r_word;
               w_ptr_next = (w_push && !w_full) ? r_ptr + 1'b1 : (w_pop && !w_empty) ? r_ptr - 1'b1 : r_ptr;
            end
            always_ff @(posedge CLK) begin
               if (w_push && !w_full)
                  r_stack[SW'(r_ptr)] <= r_word;
            end
            always_ff @(posedge CLK) begin
               if (w_rst) begin
                  r_word <= RESET_VAL;
                  r_ptr  <= '0;
                  r_err  <= 1'b0;
               end else begin
                  r_word <= w_next;
                  r_ptr  <= w_ptr_next;
                  r_err  <= r_err || (w_push && w_full) || (w_pop && w_empty);
               end
            end
`ifdef STATE_REG_CHANGE_DET_EN
            logic r_chg;
            always_ff @(posedge CLK) begin
               if (w_rst)
                  r_chg <= 1'b0;
               else if (w_next != r_word)
                  r_chg <= 1'b1;
               else if (bus.i_chg_clr[g])
                  r_chg <= 1'b0;
            end
            assign w_chg_v[g] = r_chg;
`endif
            assign w_words[g]                        = r_word;
            assign bus.o_state_flat[g*WIDTH +: WIDTH] = r_word;
            assign w_empty_v[g]                      = w_empty;
            assign w_full_v[g]                       = w_full;
            assign w_err_v[g]                        = r_err;
         end else begin : g_pad
            assign w_words[g] = '0;
         end
      end
   endgenerate
   assign bus.o_rd_data   = w_words[bus.i_rd_ch];
   assign bus.o_stk_empty = w_empty_v;
   assign bus.o_stk_full  = w_full_v;
   assign bus.o_stk_err   = w_err_v;
`ifdef STATE_REG_CHANGE_DET_EN
   assign bus.o_change_flag = w_chg_v;
`else
   logic w_unused_chg_clr;
   assign w_unused_chg_clr  = ^bus.i_chg_clr;
   assign bus.o_change_flag = '0;
`endif
endmodule

// File: tb/tb_state_reg_bank.sv
// tb_state_reg_bank: directed and random checks of state_reg_bank against a behavioural model.
module tb_state_reg_bank;
   logic CLK = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   m_valid = 0;
   logic [7:0] m_word [4];
   logic [7:0] m_stk [4][4];
   int         m_ptr [4];
   bit         m_err [4];
   bit         m_chg [4];

   state_reg_bank_if #(.WIDTH(8), .CHANNELS(4), .CH_BITS(2)) bus ();
   state_reg_bank dut (.CLK(CLK), .reset(reset), .bus(bus));

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: apply the spec's rules channel by channel on every edge
   always @(posedge CLK) begin : model
      logic [7:0] old, nw;
      bit wr, p, q;
      for (int c = 0; c < 4; c++) begin
         if (reset || bus.i_ch_reset[c]) begin
            m_word[c] = 8'h00; m_ptr[c] = 0; m_err[c] = 0; m_chg[c] = 0;
         end else begin
            old = m_word[c];
            nw  = old;
            wr  = bus.i_wr_en && int'(bus.i_wr_ch) == c;
            p   = bus.i_push && !bus.i_pop && int'(bus.i_stk_ch) == c;
            q   = bus.i_pop && !bus.i_push && int'(bus.i_stk_ch) == c;
            if (wr)
               case (bus.i_wr_mode)
                  2'd0: nw = bus.i_wr_data;
                  2'd1: nw = old | bus.i_wr_data;
                  2'd2: nw = old & ~bus.i_wr_data;
                  default: nw = old ^ bus.i_wr_data;
               endcase
            if (p) begin
               if (m_ptr[c] < 4) begin m_stk[c][m_ptr[c]] = old; m_ptr[c]++; end
               else m_err[c] = 1;
            end
            if (q) begin
               if (m_ptr[c] > 0) begin m_ptr[c]--; nw = m_stk[c][m_ptr[c]]; end
               else m_err[c] = 1;
            end
            if (nw != old) m_chg[c] = 1;
            else if (bus.i_chg_clr[c]) m_chg[c] = 0;
            m_word[c] = nw;
         end
      end
      if (reset) m_valid = 1;
   end

   always @(negedge CLK) begin : compare
      logic [31:0] flat;
      logic [3:0] emp, ful, err, chg;
      if (m_valid) begin
         for (int c = 0; c < 4; c++) begin
            flat[c*8 +: 8] = m_word[c];
            emp[c] = m_ptr[c] == 0;
            ful[c] = m_ptr[c] == 4;
            err[c] = m_err[c];
`ifdef STATE_REG_CHANGE_DET_EN
            chg[c] = m_chg[c];
`else
            chg[c] = 1'b0;
`endif
         end
         chk("model_flat", bus.o_state_flat, flat);
         chk("model_rd", {24'h0, bus.o_rd_data}, {24'h0, m_word[bus.i_rd_ch]});
         chk("model_empty", {28'h0, bus.o_stk_empty}, {28'h0, emp});
         chk("model_full", {28'h0, bus.o_stk_full}, {28'h0, ful});
         chk("model_err", {28'h0, bus.o_stk_err}, {28'h0, err});
         chk("model_chg", {28'h0, bus.o_change_flag}, {28'h0, chg});
      end
   end

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
      #2;
   endtask

   task automatic idle();
      bus.i_ch_reset = '0; bus.i_wr_en = 0; bus.i_wr_ch = '0; bus.i_wr_mode = '0; bus.i_wr_data = '0;
      bus.i_push = 0; bus.i_pop = 0; bus.i_stk_ch = '0; bus.i_chg_clr = '0;
   endtask

   task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] d);
      bus.i_wr_en = 1; bus.i_wr_ch = ch; bus.i_wr_mode = mode; bus.i_wr_data = d;
   endtask

   initial begin
      logic [7:0] rd_seq [4];
      logic [7:0] wd_seq [4];
      rd_seq = '{8'hA5, 8'hAF, 8'h2E, 8'hD1};
      wd_seq = '{8'hA5, 8'h0A, 8'h81, 8'hFF};
      idle();
      bus.i_rd_ch = 2'd1;
      reset = 1;
      tick();
      reset = 0;
      chk("rst_flat", bus.o_state_flat, 32'h0);
      chk("rst_empty", {28'h0, bus.o_stk_empty}, 32'hF);
      chk("rst_full", {28'h0, bus.o_stk_full}, 32'h0);
      chk("rst_err", {28'h0, bus.o_stk_err}, 32'h0);
      chk("rst_chg", {28'h0, bus.o_change_flag}, 32'h0);
      // bit-level write modes on channel 1
      for (int i = 0; i < 4; i++) begin
         wr(2'd1, 2'(i), wd_seq[i]);
         tick();
         chk("mode_rd", {24'h0, bus.o_rd_data}, {24'h0, rd_seq[i]});
      end
      idle();
      chk("mode_flat", bus.o_state_flat, 32'h0000D100);
      // save/restore on channel 2
      bus.i_rd_ch = 2'd2;
      wr(2'd2, 2'd0, 8'h11); tick(); idle();
      bus.i_push = 1; bus.i_stk_ch = 2'd2; tick(); idle();
      wr(2'd2, 2'd0, 8'h22); tick(); idle();
      bus.i_push = 1; bus.i_stk_ch = 2'd2; tick(); idle();
      wr(2'd2, 2'd0, 8'h33); tick(); idle();
      chk("stk_pre_pop", {24'h0, bus.o_rd_data}, 32'h33);
      bus.i_pop = 1; bus.i_stk_ch = 2'd2; tick();
      chk("stk_pop1", {24'h0, bus.o_rd_data}, 32'h22);
      tick(); idle();
      chk("stk_pop2", {24'h0, bus.o_rd_data}, 32'h11);
      chk("stk_empty2", {31'h0, bus.o_stk_empty[2]}, 32'h1);
      chk("stk_err2", {31'h0, bus.o_stk_err[2]}, 32'h0);
      // overflow on channel 0, underflow on channel 3
      bus.i_push = 1; bus.i_stk_ch = 2'd0;
      repeat (4) tick();
      chk("ovf_full", {31'h0, bus.o_stk_full[0]}, 32'h1);
      chk("ovf_err_pre", {31'h0, bus.o_stk_err[0]}, 32'h0);
      tick(); idle();
      chk("ovf_err", {31'h0, bus.o_stk_err[0]}, 32'h1);
      chk("ovf_full_hold", {31'h0, bus.o_stk_full[0]}, 32'h1);
      bus.i_pop = 1; bus.i_stk_ch = 2'd3; tick(); idle();
      chk("unf_err", {31'h0, bus.o_stk_err[3]}, 32'h1);
      chk("unf_word", {24'h0, bus.o_state_flat[31:24]}, 32'h0);
      // collisions on channel 1
      bus.i_rd_ch = 2'd1;
      wr(2'd1, 2'd0, 8'h5C); tick(); idle();
      bus.i_push = 1; bus.i_stk_ch = 2'd1; tick(); idle();
      wr(2'd1, 2'd0, 8'h77); bus.i_pop = 1; bus.i_stk_ch = 2'd1; tick();
      chk("col_pop_wins", {24'h0, bus.o_rd_data}, 32'h5C);
      wr(2'd1, 2'd0, 8'h66); tick(); idle();
      chk("col_fail_pop_wr", {24'h0, bus.o_rd_data}, 32'h66);
      chk("col_err", {31'h0, bus.o_stk_err[1]}, 32'h1);
      bus.i_ch_reset = 4'b0010; tick(); idle();
      chk("chrst_word", {24'h0, bus.o_rd_data}, 32'h0);
      chk("chrst_err", {31'h0, bus.o_stk_err[1]}, 32'h0);
      chk("chrst_empty", {31'h0, bus.o_stk_empty[1]}, 32'h1);
      chk("chrst_other", {24'h0, bus.o_state_flat[23:16]}, 32'h11);
      // change detection on channel 3
      bus.i_chg_clr = 4'hF; tick(); idle();
      wr(2'd3, 2'd0, 8'h00); tick(); idle();
      chk("chg_same", {31'h0, bus.o_change_flag[3]}, 32'h0);
      wr(2'd3, 2'd0, 8'h01); tick(); idle();
`ifdef STATE_REG_CHANGE_DET_EN
      chk("chg_set", {31'h0, bus.o_change_flag[3]}, 32'h1);
`else
      chk("chg_set", {31'h0, bus.o_change_flag[3]}, 32'h0);
`endif
      bus.i_chg_clr = 4'b1000; tick(); idle();
      chk("chg_clr", {31'h0, bus.o_change_flag[3]}, 32'h0);
      // random traffic, model-checked every cycle
      for (int n = 0; n < 3000; n++) begin
         reset          = $urandom_range(0, 299) == 0;
         bus.i_ch_reset = $urandom_range(0, 39) == 0 ? 4'($urandom) : 4'h0;
         bus.i_wr_en    = 1'($urandom);
         bus.i_wr_ch    = 2'($urandom);
         bus.i_wr_mode  = 2'($urandom);
         bus.i_wr_data  = 8'($urandom);
         bus.i_push     = $urandom_range(0, 2) == 0;
         bus.i_pop      = $urandom_range(0, 2) == 0;
         bus.i_stk_ch   = 2'($urandom);
         bus.i_rd_ch    = 2'($urandom);
         bus.i_chg_clr  = $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'h0;
         tick();
      end
      reset = 0;
      idle();
      tick();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
